bin2seg_display: RTL and testbench

Sequential binary-to-display back end: accepts a 14-bit binary value (0..9999 valid) through a valid/ready handshake and converts it to four packed BCD digits by iterative double-dabble, one bit per cycle. It drives four 8-bit seven-segment patterns. It is the output-direction counterpart of the button-entry digit counter: that block produces count_value, and this block turns such a value back into display digits for the board's 4-digit LED display.

---
 rtl/bin2seg_display_pkg.sv | 41 ++++
 rtl/bin2seg_display_seg7_encoder.sv | 20 ++
 rtl/bin2seg_display.sv | 121 ++++++++++++
 tb/tb_bin2seg_display.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/bin2seg_display_pkg.sv
// Shared definitions for the binary-to-seven-segment display back end:
// FSM encoding, active-high segment patterns and the display range limit.
package bin2seg_display_pkg;

   typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

   localparam logic [31:0] MAX_DISPLAY = 32'd9999;

   // Active-high patterns, bit order {dp,g,f,e,d,c,b,a}
   localparam logic [7:0] SEG_0     = 8'h3F;
   localparam logic [7:0] SEG_1     = 8'h06;
   localparam logic [7:0] SEG_2     = 8'h5B;
   localparam logic [7:0] SEG_3     = 8'h4F;
   localparam logic [7:0] SEG_4     = 8'h66;
   localparam logic [7:0] SEG_5     = 8'h6D;
   localparam logic [7:0] SEG_6     = 8'h7D;
   localparam logic [7:0] SEG_7     = 8'h07;
   localparam logic [7:0] SEG_8     = 8'h7F;
   localparam logic [7:0] SEG_9     = 8'h6F;
   localparam logic [7:0] SEG_DASH  = 8'h40;
   localparam logic [7:0] SEG_BLANK = 8'h00;

   function automatic logic [7:0] digit_pattern(input logic [3:0] digit);
      logic [7:0] p;
      case (digit)
         4'd0:    p = SEG_0;
         4'd1:    p = SEG_1;
         4'd2:    p = SEG_2;
         4'd3:    p = SEG_3;
         4'd4:    p = SEG_4;
         4'd5:    p = SEG_5;
         4'd6:    p = SEG_6;
         4'd7:    p = SEG_7;
         4'd8:    p = SEG_8;
         4'd9:    p = SEG_9;
         default: p = SEG_BLANK;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/bin2seg_display_seg7_encoder.sv
// Combinational BCD digit to seven-segment encoder with blanking and
// selectable output polarity.
module seg7_encoder
   import bin2seg_display_pkg::*;
#(
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic [3:0] digit,
   input  logic       blank,
   output logic [7:0] pattern
);

   logic [7:0] lit;

   always_comb begin
      lit     = blank ? SEG_BLANK : digit_pattern(digit);
      pattern = SEG_ACTIVE_LOW ? ~lit : lit;
   end

endmodule

// File: rtl/bin2seg_display.sv
// Handshaked binary-to-BCD converter (iterative double-dabble, one bit per
// cycle) driving four registered seven-segment digit outputs.
module bin2seg_display
   import bin2seg_display_pkg::*;
#(
   parameter int WIDTH          = 14,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit BLANK_LZ       = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_value,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             done,
   output logic             ovf,
   output logic [15:0]      bcd,
   output logic [7:0]       seg0,
   output logic [7:0]       seg1,
   output logic [7:0]       seg2,
   output logic [7:0]       seg3
);

   localparam int         CNT_W    = $clog2(WIDTH + 1);
   localparam logic [7:0] SEG_OFF  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
   localparam logic [7:0] DASH_OUT = SEG_ACTIVE_LOW ? ~SEG_DASH : SEG_DASH;

   state_t           state;
   logic [WIDTH-1:0] shift_reg;
   logic [15:0]      scratch;
   logic [CNT_W-1:0] bit_cnt;
   logic             over_range;
   logic [14:0]      scratch_adj;
   logic [3:0]       blank;
   logic [3:0][7:0]  enc;

   // Add-3 correction; the top bit is dropped because a thousands carry
   // only happens for over-range values, which are masked at load.
   function automatic logic [14:0] dabble_adjust(input logic [15:0] s);
      logic [15:0] r;
      for (int k = 0; k < 4; k++)
         r[4*k +: 4] = (s[4*k +: 4] >= 4'd5) ? s[4*k +: 4] + 4'd3 : s[4*k +: 4];
      return r[14:0];
   endfunction

   assign scratch_adj = dabble_adjust(scratch);

   always_comb begin
      blank[3] = BLANK_LZ && (scratch[15:12] == 4'd0);
      blank[2] = blank[3] && (scratch[11:8] == 4'd0);
      blank[1] = blank[2] && (scratch[7:4] == 4'd0);
      blank[0] = 1'b0;
   end

   for (genvar g = 0; g < 4; g++) begin : g_enc
      seg7_encoder #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_enc (
         .digit   (scratch[4*g +: 4]),
         .blank   (blank[g]),
         .pattern (enc[g])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         in_ready   <= 1'b1;
         done       <= 1'b0;
         ovf        <= 1'b0;
         bcd        <= 16'h0000;
         seg0       <= SEG_OFF;
         seg1       <= SEG_OFF;
         seg2       <= SEG_OFF;
         seg3       <= SEG_OFF;
         shift_reg  <= '0;
         scratch    <= '0;
         bit_cnt    <= '0;
         over_range <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  shift_reg  <= in_value;
                  scratch    <= '0;
                  over_range <= 32'(in_value) > MAX_DISPLAY;
                  bit_cnt    <= CNT_W'(WIDTH - 1);
                  in_ready   <= 1'b0;
                  state      <= CONV;
               end
            end
            CONV: begin
               scratch   <= {scratch_adj, shift_reg[WIDTH-1]};
               shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
               if (bit_cnt == '0) state <= LOAD;
               else bit_cnt <= bit_cnt - 1'b1;
            end
            LOAD: begin
               ovf <= over_range;
               if (over_range) begin
                  bcd  <= 16'h0000;
                  seg0 <= DASH_OUT;
                  seg1 <= DASH_OUT;
                  seg2 <= DASH_OUT;
                  seg3 <= DASH_OUT;
               end else begin
                  bcd  <= scratch;
                  seg0 <= enc[0];
                  seg1 <= enc[1];
                  seg2 <= enc[2];
                  seg3 <= enc[3];
               end
               done     <= 1'b1;
               in_ready <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bin2seg_display.sv
// Scoreboard bench for bin2seg_display: two instances (leading-zero blanking
// on and off) share stimulus; results are checked against a decimal model.
module tb_bin2seg_display;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [13:0] in_value = '0;
   logic        in_ready, done, ovf;
   logic [15:0] bcd;
   logic [7:0]  seg0, seg1, seg2, seg3;
   logic        nb_in_ready, nb_done, nb_ovf;
   logic [15:0] nb_bcd;
   logic [7:0]  nb_seg0, nb_seg1, nb_seg2, nb_seg3;

   typedef struct packed {
      logic [15:0] bcd;
      logic        ovf;
      logic [31:0] seg;
      logic [31:0] seg_nb;
      int          acc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   acc_cnt = 0, last_acc = 0, prev_acc = 0;
   int   done_cnt = 0, last_done = 0, prev_done = 0;
   logic done_d = 1'b0;

   bin2seg_display dut (
      .clk(clk), .rst(rst), .in_value(in_value), .in_valid(in_valid),
      .in_ready(in_ready), .done(done), .ovf(ovf), .bcd(bcd),
      .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3)
   );

   bin2seg_display #(.BLANK_LZ(1'b0)) dut_nb (
      .clk(clk), .rst(rst), .in_value(in_value), .in_valid(in_valid),
      .in_ready(nb_in_ready), .done(nb_done), .ovf(nb_ovf), .bcd(nb_bcd),
      .seg0(nb_seg0), .seg1(nb_seg1), .seg2(nb_seg2), .seg3(nb_seg3)
   );

   always #10 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] req);
      checks++;
      if (obs !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, req, $time);
      end
   endtask

   function automatic logic [7:0] seg_al(input int d);
      case (d)
         0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
         4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
         8: return 8'h80;  9: return 8'h90;
         default: return 8'hFF;
      endcase
   endfunction

   function automatic exp_t model(input int v, input int acc);
      exp_t e;
      int   p, d;
      e.acc = acc;
      if (v > 9999) begin
         e.bcd = 16'h0000;
         e.ovf = 1'b1;
         e.seg = {4{8'hBF}};
         e.seg_nb = {4{8'hBF}};
      end else begin
         e.ovf = 1'b0;
         p = 1;
         for (int k = 0; k < 4; k++) begin
            d = (v / p) % 10;
            e.bcd[4*k +: 4]    = 4'(d);
            e.seg_nb[8*k +: 8] = seg_al(d);
            e.seg[8*k +: 8]    = (k > 0 && v < p) ? 8'hFF : seg_al(d);
            p = p * 10;
         end
      end
      return e;
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst && in_valid && in_ready) begin
         exp_q.push_back(model(int'(in_value), cyc));
         prev_acc <= last_acc;
         last_acc <= cyc;
         acc_cnt  <= acc_cnt + 1;
      end
   end

   always @(negedge clk) begin
      if (done && done_d) check_eq("done_width", 32'd2, 32'd1);
      done_d <= done;
      if (done && !done_d) begin
         if (exp_q.size() == 0) begin
            check_eq("unexpected_done", 32'(done), 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check_eq("latency", 32'(cyc - mon_e.acc), 32'd16);
            check_eq("bcd", 32'(bcd), 32'(mon_e.bcd));
            check_eq("ovf", 32'(ovf), 32'(mon_e.ovf));
            check_eq("seg", {seg3, seg2, seg1, seg0}, mon_e.seg);
            check_eq("nb_done", 32'(nb_done), 32'd1);
            check_eq("nb_seg", {nb_seg3, nb_seg2, nb_seg1, nb_seg0}, mon_e.seg_nb);
            prev_done <= last_done;
            last_done <= cyc;
            done_cnt  <= done_cnt + 1;
         end
      end
   end

   task automatic wait_acc(input int target);
      for (int i = 0; i < 60 && acc_cnt < target; i++) @(negedge clk);
      check_eq("accept", 32'(acc_cnt >= target), 32'd1);
   endtask

   task automatic send(input int v);
      int start;
      start    = acc_cnt;
      in_value = 14'(v);
      in_valid = 1'b1;
      wait_acc(start + 1);
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
      check_eq("drain", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
   endtask

   initial begin
      int start, d0;
      repeat (2) @(negedge clk);
      check_eq("rst_in_ready", 32'(in_ready), 32'd1);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_ovf", 32'(ovf), 32'd0);
      check_eq("rst_bcd", 32'(bcd), 32'd0);
      check_eq("rst_seg", {seg3, seg2, seg1, seg0}, 32'hFFFF_FFFF);
      in_value = 14'd1234;
      in_valid = 1'b1;
      repeat (2) @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);

      send(1052);
      wait_idle();
      check_eq("v1052_bcd", 32'(bcd), 32'h1052);
      check_eq("v1052_seg", {seg3, seg2, seg1, seg0}, 32'hF9C0_92A4);

      send(7);     wait_idle();
      check_eq("v7_seg", {seg3, seg2, seg1, seg0}, 32'hFFFF_FFF8);
      check_eq("v7_nb_seg", {nb_seg3, nb_seg2, nb_seg1, nb_seg0}, 32'hC0C0_C0F8);
      send(0);     wait_idle();
      send(9999);  wait_idle();
      send(10000); wait_idle();
      check_eq("ovf_held", 32'(ovf), 32'd1);
      send(16383); wait_idle();
      check_eq("v16383_seg", {seg3, seg2, seg1, seg0}, 32'hBFBF_BFBF);

      start    = acc_cnt;
      in_value = 14'd1234;
      in_valid = 1'b1;
      wait_acc(start + 1);
      in_value = 14'd4321;
      wait_acc(start + 2);
      in_valid = 1'b0;
      check_eq("b2b_accept_gap", 32'(last_acc - prev_acc), 32'd16);
      wait_idle();
      check_eq("b2b_done_gap", 32'(last_done - prev_done), 32'd16);
      check_eq("b2b_bcd", 32'(bcd), 32'h4321);

      send(8888);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      d0 = done_cnt;
      #1;
      check_eq("mid_rst_seg", {seg3, seg2, seg1, seg0}, 32'hFFFF_FFFF);
      check_eq("mid_rst_bcd", 32'(bcd), 32'd0);
      check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
      check_eq("mid_rst_done", 32'(done), 32'd0);
      in_value = 14'd5;
      in_valid = 1'b1;
      repeat (2) @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check_eq("no_done_after_rst", 32'(done_cnt - d0), 32'd0);

      send(42);
      wait_idle();
      check_eq("v42_bcd", 32'(bcd), 32'h0042);
      check_eq("v42_seg", {seg3, seg2, seg1, seg0}, 32'hFFFF_99A4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, time %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
